// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the ID stage and the forwarding/hazard unit.
// The ID stage (master) drives the decoded instruction fields and the
// flush request; the unit (slave) returns stall, forwarding selects and
// the tracked downstream destination registers.
interface fwd_hazard_unit_if #(
  parameter int CNT_W = 16
);

  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;

  logic             stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [4:0]       ex_rd;
  logic [4:0]       mem_rd;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, flush,
    input  stall, fwd_a, fwd_b, ex_rd, mem_rd, wb_rd, wb_regwrite, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread, flush,
    output stall, fwd_a, fwd_b, ex_rd, mem_rd, wb_rd, wb_regwrite, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for a classic 5-stage pipeline.
// Keeps a shadow copy of the register-index fields of the EX, MEM and WB
// stages, raises a one-cycle stall for load-use pairs, selects the EX
// operand bypass sources and counts stall cycles (saturating).
module fwd_hazard_unit #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  fwd_hazard_unit_if.slave bus
);

  localparam logic [1:0] SEL_IDEX = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;

  logic [4:0]       ex_rs_q;
  logic [4:0]       ex_rt_q;
  logic [4:0]       ex_rd_q;
  logic             ex_regwrite_q;
  logic             ex_memread_q;
  logic [4:0]       mem_rd_q;
  logic             mem_regwrite_q;
  logic [4:0]       wb_rd_q;
  logic             wb_regwrite_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             stall_c;
  logic             ex_load;
  logic [1:0]       fwd_a_c;
  logic [1:0]       fwd_b_c;

  // Bypass source for one EX operand; the MEM stage holds the newer value
  // so it is checked first, and register 0 is never bypassed.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] m_rd,
    input logic       m_rw,
    input logic [4:0] w_rd,
    input logic       w_rw
  );
    logic [1:0] sel;
    sel = SEL_IDEX;
    if (m_rw && (m_rd != 5'd0) && (m_rd == src)) begin
      sel = SEL_MEM;
    end else if (w_rw && (w_rd != 5'd0) && (w_rd == src)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

  // Load-use detection: a load in EX whose destination is read by the ID
  // instruction; a flushed ID instruction never stalls.
  always_comb begin
    stall_c = 1'b0;
    if (bus.id_valid && !bus.flush && ex_memread_q && (ex_rd_q != 5'd0) &&
        ((ex_rd_q == bus.id_rs) || (ex_rd_q == bus.id_rt))) begin
      stall_c = 1'b1;
    end
    ex_load = bus.id_valid && !stall_c && !bus.flush;
  end

  // Operand bypass selects, derived purely from registered stage state.
  always_comb begin
    fwd_a_c = fwd_sel(ex_rs_q, mem_rd_q, mem_regwrite_q, wb_rd_q, wb_regwrite_q);
    fwd_b_c = fwd_sel(ex_rt_q, mem_rd_q, mem_regwrite_q, wb_rd_q, wb_regwrite_q);
  end

  // EX shadow stage: takes the ID instruction, or a bubble on stall/flush/invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_q       <= 5'd0;
      ex_rt_q       <= 5'd0;
      ex_rd_q       <= 5'd0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
    end else if (ex_load) begin
      ex_rs_q       <= bus.id_rs;
      ex_rt_q       <= bus.id_rt;
      ex_rd_q       <= bus.id_rd;
      ex_regwrite_q <= bus.id_regwrite;
      ex_memread_q  <= bus.id_memread;
    end else begin
      ex_rs_q       <= 5'd0;
      ex_rt_q       <= 5'd0;
      ex_rd_q       <= 5'd0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
    end
  end

  // MEM and WB shadow stages advance every cycle; only rd/regwrite matter here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_q       <= 5'd0;
      mem_regwrite_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_regwrite_q  <= 1'b0;
    end else begin
      mem_rd_q       <= ex_rd_q;
      mem_regwrite_q <= ex_regwrite_q;
      wb_rd_q        <= mem_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
    end
  end

  // Stall-cycle counter, held at all-ones once it gets there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.fwd_a       = fwd_a_c;
  assign bus.fwd_b       = fwd_b_c;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_regwrite = wb_regwrite_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit. Instruction sequences are driven
// one per cycle; the expected observation for each cycle is pushed to a
// scoreboard queue when the stimulus is driven and popped at the falling
// edge, where the outputs are compared.
module tb_fwd_hazard_unit;

  localparam int CW = 4;

  typedef logic [24:0] obs_t;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       st;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [4:0] exrd;
  } step_t;

  typedef struct {
    string name;
    obs_t  val;
    obs_t  mask;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  fwd_hazard_unit_if #(.CNT_W(CW)) bus ();

  fwd_hazard_unit #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack {stall, fwd_a, fwd_b, ex_rd, mem_rd, wb_rd, wb_regwrite, stall_cnt}.
  function automatic obs_t pk(input int st, input int fa, input int fb, input int exrd,
                              input int memrd, input int wbrd, input int wbrw, input int cnt);
    return {1'(st), 2'(fa), 2'(fb), 5'(exrd), 5'(memrd), 5'(wbrd), 1'(wbrw), 4'(cnt)};
  endfunction

  function automatic obs_t sample();
    return {bus.stall, bus.fwd_a, bus.fwd_b, bus.ex_rd, bus.mem_rd, bus.wb_rd,
            bus.wb_regwrite, bus.stall_cnt};
  endfunction

  function automatic step_t mk(input int v, input int rs, input int rt, input int rd,
                               input int rw, input int mr, input int fl, input int st,
                               input int fa, input int fb, input int exrd);
    step_t s;
    s.v = 1'(v); s.rs = 5'(rs); s.rt = 5'(rt); s.rd = 5'(rd);
    s.rw = 1'(rw); s.mr = 1'(mr); s.fl = 1'(fl);
    s.st = 1'(st); s.fa = 2'(fa); s.fb = 2'(fb); s.exrd = 5'(exrd);
    return s;
  endfunction

  function automatic obs_t exp_of(input step_t s);
    return pk(int'(s.st), int'(s.fa), int'(s.fb), int'(s.exrd), 0, 0, 0, 0);
  endfunction

  task automatic drive(input step_t s);
    bus.id_valid    = s.v;
    bus.id_rs       = s.rs;
    bus.id_rt       = s.rt;
    bus.id_rd       = s.rd;
    bus.id_regwrite = s.rw;
    bus.id_memread  = s.mr;
    bus.flush       = s.fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Reset state, both before any clock and across a clock edge with a valid ID.
  task automatic test_reset();
    exp_t e;
    obs_t obs;
    rst_n = 1'b0;
    drive(mk(1, 4, 4, 3, 1, 1, 0, 0, 0, 0, 0));
    sb.push_back('{"reset_no_clock", pk(0, 0, 0, 0, 0, 0, 0, 0), '1});
    #2;
    e = sb.pop_front(); obs = sample(); n_checks++;
    if (obs !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h required %h", e.name, obs, e.val);
    end
    sb.push_back('{"reset_held_edge", pk(0, 0, 0, 0, 0, 0, 0, 0), '1});
    @(posedge clk); #1;
    e = sb.pop_front(); obs = sample(); n_checks++;
    if (obs !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h required %h", e.name, obs, e.val);
    end
  endtask

  // add r3 then dependent sub (rs), then an rt dependency at distance 1.
  task automatic test_back_to_back();
    step_t steps[$];
    exp_t  e;
    obs_t  obs;
    obs_t  m;
    m = pk(1, 3, 3, 31, 0, 0, 0, 0);
    do_reset();
    steps.push_back(mk(1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0));
    steps.push_back(mk(1, 3, 7, 8, 1, 0, 0, 0, 0, 0, 3));
    steps.push_back(mk(1, 1, 1, 9, 1, 0, 0, 0, 2, 0, 8));
    steps.push_back(mk(1, 10, 9, 11, 1, 0, 0, 0, 0, 0, 9));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 11));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      sb.push_back('{$sformatf("b2b_step%0d", i), exp_of(steps[i]), m});
      @(negedge clk);
      e = sb.pop_front(); obs = sample(); n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("[TB] FAIL %s: observed %h required %h", e.name, obs & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  // or r5, unrelated add, then and with rt=r5 -> WB bypass on operand B.
  task automatic test_distance_two();
    step_t steps[$];
    exp_t  e;
    obs_t  obs;
    obs_t  m;
    m = pk(1, 3, 3, 31, 0, 0, 0, 0);
    do_reset();
    steps.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0));
    steps.push_back(mk(1, 6, 7, 8, 1, 0, 0, 0, 0, 0, 5));
    steps.push_back(mk(1, 9, 5, 10, 1, 0, 0, 0, 0, 0, 8));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      sb.push_back('{$sformatf("dist2_step%0d", i), exp_of(steps[i]), m});
      @(negedge clk);
      e = sb.pop_front(); obs = sample(); n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("[TB] FAIL %s: observed %h required %h", e.name, obs & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  // Load-use on rs, a load without a dependent, then load-use on rt.
  task automatic test_load_use();
    step_t steps[$];
    exp_t  e;
    obs_t  obs;
    obs_t  m;
    m = pk(1, 3, 3, 31, 0, 0, 0, 0);
    do_reset();
    steps.push_back(mk(1, 1, 4, 4, 1, 1, 0, 0, 0, 0, 0));
    steps.push_back(mk(1, 4, 2, 6, 1, 0, 0, 1, 0, 0, 4));
    steps.push_back(mk(1, 4, 2, 6, 1, 0, 0, 0, 0, 0, 0));
    steps.push_back(mk(1, 1, 7, 7, 1, 1, 0, 0, 1, 0, 6));
    steps.push_back(mk(1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 7));
    steps.push_back(mk(1, 2, 9, 9, 1, 1, 0, 0, 0, 0, 3));
    steps.push_back(mk(1, 1, 9, 2, 1, 0, 0, 1, 0, 0, 9));
    steps.push_back(mk(1, 1, 9, 2, 1, 0, 0, 0, 0, 0, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      sb.push_back('{$sformatf("loaduse_step%0d", i), exp_of(steps[i]), m});
      @(negedge clk);
      e = sb.pop_front(); obs = sample(); n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("[TB] FAIL %s: observed %h required %h", e.name, obs & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
    sb.push_back('{"loaduse_stall_cnt", pk(0, 0, 0, 0, 0, 0, 0, 2), pk(0, 0, 0, 0, 0, 0, 0, 15)});
    e = sb.pop_front(); obs = sample(); n_checks++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h required %h", e.name, obs & e.mask, e.val & e.mask);
    end
  endtask

  // r0 writes/uses, flush over a load-use, non-writing and invalid instructions.
  task automatic test_zero_and_flush();
    step_t steps[$];
    exp_t  e;
    obs_t  obs;
    obs_t  m;
    m = pk(1, 3, 3, 31, 0, 0, 0, 0);
    do_reset();
    steps.push_back(mk(1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0));
    steps.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0));
    steps.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 5));
    steps.push_back(mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    steps.push_back(mk(1, 1, 2, 4, 1, 1, 0, 0, 0, 0, 0));
    steps.push_back(mk(1, 4, 4, 7, 1, 0, 1, 0, 0, 0, 4));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    steps.push_back(mk(1, 1, 2, 8, 0, 0, 0, 0, 0, 0, 0));
    steps.push_back(mk(1, 8, 8, 9, 1, 0, 0, 0, 0, 0, 8));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9));
    steps.push_back(mk(0, 1, 2, 3, 1, 1, 0, 0, 0, 0, 0));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      sb.push_back('{$sformatf("zero_flush_step%0d", i), exp_of(steps[i]), m});
      @(negedge clk);
      e = sb.pop_front(); obs = sample(); n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("[TB] FAIL %s: observed %h required %h", e.name, obs & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  // r6 written at distance 1 and 2; the newer MEM value must win on both operands.
  task automatic test_double_match();
    step_t steps[$];
    exp_t  e;
    obs_t  obs;
    obs_t  m;
    m = pk(1, 3, 3, 31, 0, 0, 0, 0);
    do_reset();
    steps.push_back(mk(1, 1, 2, 6, 1, 0, 0, 0, 0, 0, 0));
    steps.push_back(mk(1, 1, 2, 6, 1, 0, 0, 0, 0, 0, 6));
    steps.push_back(mk(1, 6, 6, 7, 1, 0, 0, 0, 0, 0, 6));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 7));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      sb.push_back('{$sformatf("double_step%0d", i), exp_of(steps[i]), m});
      @(negedge clk);
      e = sb.pop_front(); obs = sample(); n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("[TB] FAIL %s: observed %h required %h", e.name, obs & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
    end
  endtask

  // Mid-stream asynchronous reset clears everything; the next instruction sees no bypass.
  task automatic test_async_reset();
    exp_t e;
    obs_t obs;
    do_reset();
    drive(mk(1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0)); @(posedge clk); #1;
    drive(mk(1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0)); @(posedge clk); #1;
    drive(mk(1, 1, 4, 4, 1, 1, 0, 0, 0, 0, 0)); @(posedge clk); #1;
    drive(mk(1, 4, 3, 6, 1, 0, 0, 0, 0, 0, 0));
    sb.push_back('{"arst_before_stall", pk(1, 0, 0, 4, 3, 2, 1, 0), '1});
    sb.push_back('{"arst_after_stall", pk(0, 0, 0, 0, 4, 3, 1, 1), '1});
    sb.push_back('{"arst_asserted", pk(0, 0, 0, 0, 0, 0, 0, 0), '1});
    sb.push_back('{"arst_first_after", pk(0, 0, 0, 6, 0, 0, 0, 0), '1});
    @(negedge clk);
    e = sb.pop_front(); obs = sample(); n_checks++;
    if (obs !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h required %h", e.name, obs, e.val);
    end
    @(posedge clk); #1;
    @(negedge clk);
    e = sb.pop_front(); obs = sample(); n_checks++;
    if (obs !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h required %h", e.name, obs, e.val);
    end
    rst_n = 1'b0;
    #1;
    e = sb.pop_front(); obs = sample(); n_checks++;
    if (obs !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h required %h", e.name, obs, e.val);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    e = sb.pop_front(); obs = sample(); n_checks++;
    if (obs !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h required %h", e.name, obs, e.val);
    end
    @(posedge clk); #1;
  endtask

  // Twenty load-use pairs against a 4-bit counter: it must stop at 15.
  task automatic test_saturation();
    exp_t e;
    obs_t obs;
    obs_t m;
    m = pk(1, 0, 0, 0, 0, 0, 0, 15);
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      drive(mk(1, 1, 2, 4, 1, 1, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      drive(mk(1, 4, 2, 5, 1, 0, 0, 0, 0, 0, 0));
      sb.push_back('{$sformatf("sat_iter%0d", k), pk(1, 0, 0, 0, 0, 0, 0, (k - 1 > 15) ? 15 : k - 1), m});
      @(negedge clk);
      e = sb.pop_front(); obs = sample(); n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("[TB] FAIL %s: observed %h required %h", e.name, obs & e.mask, e.val & e.mask);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    sb.push_back('{"sat_final", pk(0, 0, 0, 0, 0, 0, 0, 15), m});
    e = sb.pop_front(); obs = sample(); n_checks++;
    if ((obs & e.mask) !== (e.val & e.mask)) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h required %h", e.name, obs & e.mask, e.val & e.mask);
    end
  endtask

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_back_to_back();
    test_distance_two();
    test_load_use();
    test_zero_and_flush();
    test_double_match();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 id_valid  input  1  the instruction in ID is valid.
REQ-005 id_rs  input  5  rs field of the ID instruction.
REQ-006 id_rt  input  5  rt field of the ID instruction.
REQ-007 id_rd  input  5  destination register of the ID instruction, after the RegDst choice.
REQ-008 id_regwrite  input  1  the ID instruction writes the register file.
REQ-009 id_memread  input  1  the ID instruction is a load.
REQ-010 flush  input  1  branch/jump taken; the ID instruction is killed.
REQ-011 stall  output  1  load-use hazard; the PC and IF/ID register hold.
REQ-012 fwd_a  output  2  select for the EX operand-A 4:1 mux: 00 = ID/EX register value, 01 = MEM/WB writeback, 10 = EX/MEM ALU result, 11 = never driven.
REQ-013 fwd_b  output  2  same encoding as fwd_a, for operand B.
REQ-014 ex_rd  output  5  tracked EX-stage destination register.
REQ-015 mem_rd  output  5  tracked MEM-stage destination register.
REQ-016 wb_rd  output  5  tracked WB-stage destination register.
REQ-017 wb_regwrite  output  1  tracked WB-stage write enable.
REQ-018 stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-019 The block SHALL hold three shadow stages, EX, MEM and WB, each with {rs, rt, rd, regwrite, memread}.
- MEM and WB track only rd and regwrite.
REQ-020 EX load: each clock, EX SHALL capture the ID fields when id_valid=1, stall=0 and flush=0.
- Otherwise EX loads a bubble: all fields 0.
REQ-021 MEM SHALL load EX, and WB SHALL load MEM, every clock, unconditionally.
REQ-022 stall SHALL be combinational: stall = id_valid AND NOT flush AND ex_memread AND ex_rd != 0 AND (ex_rd == id_rs OR ex_rd == id_rt).
REQ-023 A load-use pair SHALL produce exactly one stall cycle.
- The bubble inserted by the stall clears ex_memread, which releases the stall.
REQ-024 fwd_a SHALL be decided in priority order:
- 10 if mem_regwrite AND mem_rd != 0 AND mem_rd == ex_rs;
- else 01 if wb_regwrite AND wb_rd != 0 AND wb_rd == ex_rs;
- else 00.
REQ-025 fwd_b SHALL follow the same rule as fwd_a, using ex_rt in place of ex_rs.
REQ-026 fwd_a and fwd_b SHALL depend only on registered state, so they are stable for the whole cycle.
- They SHALL never take the value 11.
REQ-027 Register 0 SHALL never be forwarded and SHALL never cause a stall.
REQ-028 When MEM and WB both match the same register, MEM (the newer value) SHALL win.
REQ-029 When flush and a hazard occur in the same cycle, flush SHALL win: stall=0 and a bubble enters EX.
REQ-030 stall_cnt SHALL increment by 1 on every clock where stall=1.
- It saturates at all-ones and never wraps.
REQ-031 The ID/EX, EX/MEM and MEM/WB data paths and the register file are outside this block.
- Write-before-read in the register file is handled there.

Reset
REQ-032 While rst_n=0, all stage registers and stall_cnt SHALL be 0 immediately, with no clock edge required.
- Consequently stall=0, fwd_a=00, fwd_b=00, ex_rd=mem_rd=wb_rd=0 and wb_regwrite=0.
REQ-033 Deasserting reset in the middle of a sequence SHALL discard all in-flight hazards.
- The first instruction after reset sees no forwarding.

Verification
REQ-034 Back-to-back ALU dependency: add r3 then sub using rs=r3 -> in the sub's EX cycle fwd_a=10, fwd_b=00, stall never 1.
REQ-035 Distance-2 dependency: or writing r5, one unrelated instruction, then and with rt=r5 -> fwd_b=01 in the and's EX cycle.
REQ-036 Load-use: lw writing r4, then add with rs=r4 -> stall=1 for exactly one cycle, EX holds a bubble, then fwd_a=01 and stall_cnt=1.
REQ-037 Zero register and flush:
- Writes to r0 followed by uses of r0 -> fwd_a/fwd_b stay 00 and stall stays 0.
- Load-use with flush=1 -> stall=0 and ex_rd=0 on the next cycle.
REQ-038 Double match: r6 written at distance 1 and distance 2, then a use of r6 -> fwd_a=10.
- Assert rst_n=0 mid-stream -> all outputs 0 asynchronously.
- Force more than 2^CNT_W stalls (with CNT_W=4) -> stall_cnt holds at 15.
